// File: rtl/ase_umsg_engine.sv
// Per-AFU UMsg delivery engine: one hint/data state machine per UMsg slot,
// round-robin arbitrated onto a registered RX0 UMsg response port.
//
// state          | meaning
// UMSG_IDLE      | slot empty, waiting for a UMsg line write
// UMSG_HINT_WAIT | hint enabled, counting HINT_DELAY cycles before hinting
// UMSG_SEND_HINT | hint requested, waiting for arbiter grant
// UMSG_DATA_WAIT | counting DATA_DELAY cycles before delivering data
// UMSG_SEND_DATA | data requested, waiting for grant; new writes stall here
module ase_umsg_engine #(
  parameter int NUM_UMSG    = 8,
  parameter int HINT_DELAY  = 4,
  parameter int DATA_DELAY  = 8,
  parameter int TIMER_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        sys_reset_n,
  input  logic                        umsg_cmd_valid,
  output logic                        umsg_cmd_ready,
  input  logic [$clog2(NUM_UMSG)-1:0] umsg_cmd_id,
  input  logic [511:0]                umsg_cmd_data,
  input  logic [NUM_UMSG-1:0]         umsg_hint_mask,
  output logic                        rx0_umsg_valid,
  input  logic                        rx0_umsg_ready,
  output logic [27:0]                 rx0_umsg_hdr,
  output logic [511:0]                rx0_umsg_data,
  output logic                        umsg_busy
);

  localparam int IDW = $clog2(NUM_UMSG);
  localparam logic [TIMER_WIDTH-1:0] HINT_LAST = TIMER_WIDTH'(HINT_DELAY - 1);
  localparam logic [TIMER_WIDTH-1:0] DATA_LAST = TIMER_WIDTH'(DATA_DELAY - 1);

  typedef enum logic [2:0] {
    UMSG_IDLE,
    UMSG_HINT_WAIT,
    UMSG_SEND_HINT,
    UMSG_DATA_WAIT,
    UMSG_SEND_DATA
  } umsg_state_e;

  umsg_state_e              state_q [NUM_UMSG];
  umsg_state_e              state_d [NUM_UMSG];
  logic [TIMER_WIDTH-1:0]   timer_q [NUM_UMSG];
  logic [TIMER_WIDTH-1:0]   timer_d [NUM_UMSG];
  logic [511:0]             data_q  [NUM_UMSG];
  logic [IDW-1:0]           ptr_q;
  logic [IDW-1:0]           winner;
  logic [IDW-1:0]           scan_idx;
  logic [NUM_UMSG-1:0]      req;
  logic [NUM_UMSG-1:0]      grant;
  logic [NUM_UMSG-1:0]      accept;
  logic                     grant_any;
  logic                     load;
  logic                     win_hint;

  assign umsg_cmd_ready = (state_q[umsg_cmd_id] != UMSG_SEND_DATA);

  always_comb begin
    req       = '0;
    umsg_busy = 1'b0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      req[i] = (state_q[i] == UMSG_SEND_HINT) || (state_q[i] == UMSG_SEND_DATA);
      if (state_q[i] != UMSG_IDLE) umsg_busy = 1'b1;
    end
  end

  // First requester at or after the pointer, wrapping modulo NUM_UMSG.
  always_comb begin
    grant_any = 1'b0;
    winner    = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < NUM_UMSG; k++) begin
      scan_idx = ptr_q + IDW'(k);
      if (!grant_any && req[scan_idx]) begin
        grant_any = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  assign load     = (!rx0_umsg_valid || rx0_umsg_ready) && grant_any;
  assign win_hint = (state_q[winner] == UMSG_SEND_HINT);

  always_comb begin
    grant  = '0;
    accept = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      grant[i]  = load && (winner == IDW'(i));
      accept[i] = umsg_cmd_valid && umsg_cmd_ready && (umsg_cmd_id == IDW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        UMSG_IDLE: begin
          if (accept[i]) begin
            timer_d[i] = '0;
            state_d[i] = umsg_hint_mask[i] ? UMSG_HINT_WAIT : UMSG_DATA_WAIT;
          end
        end
        UMSG_HINT_WAIT: begin
          if (timer_q[i] == HINT_LAST) state_d[i] = UMSG_SEND_HINT;
          else                         timer_d[i] = timer_q[i] + TIMER_WIDTH'(1);
        end
        UMSG_SEND_HINT: begin
          if (grant[i]) begin
            timer_d[i] = '0;
            state_d[i] = UMSG_DATA_WAIT;
          end
        end
        UMSG_DATA_WAIT: begin
          if (timer_q[i] == DATA_LAST) state_d[i] = UMSG_SEND_DATA;
          else                         timer_d[i] = timer_q[i] + TIMER_WIDTH'(1);
        end
        UMSG_SEND_DATA: begin
          if (grant[i]) state_d[i] = UMSG_IDLE;
        end
        default: state_d[i] = UMSG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= UMSG_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Any accepted write, including a coalescing one, replaces the stored line.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_UMSG; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        if (accept[i]) data_q[i] <= umsg_cmd_data;
      end
    end
  end

  // Header: [27:20] zero, [19:16] resp_type, [15] umsg_type, [14:6] zero, [5:0] umsg_id.
  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rx0_umsg_valid <= 1'b0;
      rx0_umsg_hdr   <= '0;
      rx0_umsg_data  <= '0;
      ptr_q          <= '0;
    end else if (load) begin
      rx0_umsg_valid <= 1'b1;
      rx0_umsg_hdr   <= {8'h00, 4'hF, win_hint, 9'h000, 6'(winner)};
      rx0_umsg_data  <= win_hint ? '0 : data_q[winner];
      ptr_q          <= winner + IDW'(1);
    end else if (rx0_umsg_ready) begin
      rx0_umsg_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ase_umsg_engine.md
Name: ase_umsg_engine

Overview:
- Per-AFU UMsg delivery engine for the ASE CCI-P emulator.
- Accepts UMsg line writes arriving from the software side. Each write carries an id and 512-bit data.
- Runs one hint/data state machine per UMsg slot (UMsgIdle, UMsgHintWait, UMsgSendHint, UMsgDataWait, UMsgSendData).
- Arbitrates the slots round-robin onto a registered RX0 UMsg output, which the downstream RX0 channel mux consumes.

Parameters:
- NUM_UMSG, 8, number of UMsg slots per AFU; power of 2, at least 2.
- HINT_DELAY, 4, cycles a slot spends in UMsgHintWait; minimum 1.
- DATA_DELAY, 8, cycles a slot spends in UMsgDataWait; minimum 1.
- TIMER_WIDTH, 8, delay counter width; must satisfy 2^TIMER_WIDTH >= max(HINT_DELAY, DATA_DELAY).

Ports:
- clk  in  1  single clock.
- sys_reset_n  in  1  asynchronous, active-low reset.
- umsg_cmd_valid  in  1  UMsg write command valid.
- umsg_cmd_ready  out  1  command accepted on the same edge as valid.
- umsg_cmd_id  in  $clog2(NUM_UMSG)  target slot.
- umsg_cmd_data  in  512  line data.
- umsg_hint_mask  in  NUM_UMSG  per-slot hint enable, sampled when a command is accepted.
- rx0_umsg_valid  out  1  UMsg response valid (registered).
- rx0_umsg_ready  in  1  downstream accepts the response.
- rx0_umsg_hdr  out  28  UMsgHdr_t-format header.
- rx0_umsg_data  out  512  response data.
- umsg_busy  out  1  OR of (slot state != UMsgIdle) over all slots.

Behaviour:
- Reset (asynchronous assert, synchronous release edge):
  - all slots UMsgIdle; timers 0; stored data 0.
  - rx0_umsg_valid 0; rx0_umsg_hdr 0; rx0_umsg_data 0.
  - round-robin pointer 0; umsg_busy 0.
  - Reset mid-operation discards all pending hints and data. No response is emitted after release until a new command arrives.
- umsg_cmd_ready is combinational: 0 when slot[umsg_cmd_id] is in UMsgSendData, else 1. A transfer occurs when valid and ready are both high.
- Accept into an Idle slot:
  - store data; sample hint_en = umsg_hint_mask[id].
  - timer <= 0; next state UMsgHintWait if hint_en, else UMsgDataWait.
- Accept into a slot in HintWait, SendHint or DataWait: coalesce. Stored data is overwritten; state and timer are unchanged.
- UMsgHintWait: if timer == HINT_DELAY-1, go to UMsgSendHint; else timer+1. The state therefore lasts exactly HINT_DELAY cycles.
- UMsgSendHint: stay until granted. On grant: timer <= 0, go to UMsgDataWait.
- UMsgDataWait: if timer == DATA_DELAY-1, go to UMsgSendData; else timer+1.
- UMsgSendData: stay until granted. On grant, go to UMsgIdle.
- Output register loads when (!rx0_umsg_valid || rx0_umsg_ready) and at least one slot is in SendHint or SendData.
  - Winner is the first requesting slot at or after the pointer, searching modulo NUM_UMSG.
  - After a grant, pointer <= (winner+1) mod NUM_UMSG. The pointer holds when there is no grant.
  - A hint and a data request from different slots are treated identically by the arbiter.
- If the output register is not reloaded and rx0_umsg_ready=1, rx0_umsg_valid falls to 0.
- Output is held stable while valid && !ready.
- Header fields:
  - resp_type = 4'hF.
  - umsg_type = 1 for hint, 0 for data.
  - umsg_id = winner.
  - poison = 0; all reserved bits 0.
- Data: hint responses carry all zeros; data responses carry the slot's stored data as sampled at grant.
- Latency, no contention, hint enabled: command accepted at edge 0; rx0_umsg_valid with the hint at edge HINT_DELAY+1.
- Latency after hint accepted at edge h: data valid at edge h+DATA_DELAY+1, provided the output is free.
- Hint disabled: data valid at edge DATA_DELAY+1 after accept.
- Simultaneous events:
  - A coalescing write on the grant edge of SendHint is accepted; the data delivered later is the new data.
  - A write to a slot in SendData is stalled (ready=0) until the edge after that slot's grant, when it restarts from Idle.
- Timers never wrap: each counts only to its DELAY-1 limit.

Test Plan:
- Reset, then mask=8'h01, write id0 data=A at edge 0, ready=1:
  - hint (hdr umsg_type=1, id=0, data=0) valid at edge 5.
  - data (umsg_type=0, data=A) valid at edge 14.
  - umsg_busy falls after the data grant.
- mask=0, write id3 data=B: single data response, id=3, data=B, at edge 9; no hint emitted.
- mask=0, write id2=C, then id2=D three cycles later during DataWait:
  - one response only, data=D, at edge 9 relative to the first write.
  - cmd_ready stays 1 throughout.
- mask=0, write ids 0,1,2 on the same-cycle-aligned schedule, rx0_umsg_ready=0 for 20 cycles then 1:
  - grant order 0,1,2; responses held stable while stalled.
  - writes to id0 see cmd_ready=0 while it is in SendData.
- Arbitration fairness: ids 5 and 6 both reach SendData together with pointer=6 → id6 is granted first, then id5.
- Assert sys_reset_n=0 while id1 is in HintWait: all outputs 0 immediately; no response for id1 after release.
